dmem_responder: RTL

- Memory-side responder for the CPU data-memory port; replaces the zero-latency combinational data memory with a handshaked, multi-cycle, byte-addressable slave.
- Accepts one load/store request at a time and performs it after a fixed latency.
- Returns read data, or a write acknowledge, through a response channel with backpressure.
- Sits between the core's load/store path and a word-organised storage array.

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the alignment check used when a request is performed.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Size 11 is not treated as misaligned here; the caller flags it separately.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-aligned CPU data and the 32-bit storage word:
// store lane mask / replicated write data, and load extraction with extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  logic [15:0] lane;

  // Shifting the addressed lane down to bit 0 serves both byte and half loads.
  assign lane = 16'(rword >> {addr_lo, 3'b000});

  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    rdata      = 32'h0;
    case (size)
      SZ_BYTE: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata      = is_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata      = is_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
      end
      SZ_WORD: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        rdata      = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory slave: one request at a time, performed a
// fixed number of cycles after acceptance, answered on a backpressured channel.
//
// state   | meaning
// IDLE    | ready for a request; fields latched on accept
// WAIT    | latency countdown; access performed when counter reaches 0
// RESP    | response held until rsp_ready
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic              acc_err;
  logic              commit;
  logic [3:0]        wmask;
  logic [31:0]       wdata_lane;
  logic [31:0]       load_data;

  assign idx     = lat_addr[IDX_W+1:2];
  assign acc_err = (lat_size == SZ_ILL) || misaligned(lat_size, lat_addr[1:0]) ||
                   (lat_addr[31:IDX_W+2] != '0);
  assign commit  = (state == ST_WAIT) && (cnt == '0);

  dmem_lane_align u_align (
    .size        (lat_size),
    .addr_lo     (lat_addr[1:0]),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .rword       (mem[idx]),
    .wmask       (wmask),
    .wdata_lane  (wdata_lane),
    .rdata       (load_data)
  );

  // Storage is never reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && lat_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= 32'h0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            cnt          <= CNT_INIT;
            req_ready    <= 1'b0;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || lat_write) ? 32'h0 : load_data;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
